// File: rtl/rv_pkg.sv
// rtl/rv_pkg.sv - opcode, control-code, state and trap-cause constants for uc_mc
package rv_pkg;

    localparam logic [6:0] OP_R      = 7'b0110011;
    localparam logic [6:0] OP_I      = 7'b0010011;
    localparam logic [6:0] OP_LOAD   = 7'b0000011;
    localparam logic [6:0] OP_STORE  = 7'b0100011;
    localparam logic [6:0] OP_BRANCH = 7'b1100011;
    localparam logic [6:0] OP_JAL    = 7'b1101111;
    localparam logic [6:0] OP_JALR   = 7'b1100111;
    localparam logic [6:0] OP_LUI    = 7'b0110111;

    localparam logic [3:0] ALU_ADD    = 4'b0000;
    localparam logic [3:0] ALU_SUB    = 4'b1000;
    localparam logic [3:0] ALU_PASS_B = 4'b1111;

    localparam logic [1:0] PC_PLUS4  = 2'b00;
    localparam logic [1:0] PC_TARGET = 2'b01;
    localparam logic [1:0] PC_JALR   = 2'b10;
    localparam logic [1:0] PC_TRAP   = 2'b11;

    localparam logic [1:0] RF_ALU = 2'b00;
    localparam logic [1:0] RF_MDR = 2'b01;
    localparam logic [1:0] RF_PC4 = 2'b10;

    localparam logic [2:0] ST_FETCH  = 3'd0;
    localparam logic [2:0] ST_DECODE = 3'd1;
    localparam logic [2:0] ST_EXEC   = 3'd2;
    localparam logic [2:0] ST_MEM    = 3'd3;
    localparam logic [2:0] ST_WB     = 3'd4;
    localparam logic [2:0] ST_TRAP   = 3'd5;

    typedef enum logic [1:0] {
        CAUSE_NONE    = 2'b00,
        CAUSE_ILLEGAL = 2'b01,
        CAUSE_TIMEOUT = 2'b10
    } trap_cause_e;

    // flags = {zero, neg, carry, ovf} from a subtract; carry set means a >= b unsigned
    function automatic logic branch_taken(input logic [2:0] funct3, input logic [3:0] flags);
        logic lt_s;
        logic taken;
        lt_s = flags[2] ^ flags[0];
        case (funct3)
            3'b000:  taken = flags[3];
            3'b001:  taken = !flags[3];
            3'b100:  taken = lt_s;
            3'b101:  taken = !lt_s;
            3'b110:  taken = !flags[1];
            3'b111:  taken = flags[1];
            default: taken = 1'b0;
        endcase
        return taken;
    endfunction

endpackage

// File: rtl/uc_mc_if.sv
// rtl/uc_mc_if.sv - instruction/data memory request-acknowledge bundle
interface uc_mc_if;

    logic i_req;
    logic i_ack;
    logic d_req;
    logic d_we;
    logic d_ack;

    modport master (output i_req, d_req, d_we, input i_ack, d_ack);
    modport slave  (input i_req, d_req, d_we, output i_ack, d_ack);

endinterface

// File: rtl/rv_alu_dec.sv
// rtl/rv_alu_dec.sv - maps opcode/funct3/funct7_5 to alu_cmd, alu_src and an illegal flag
module rv_alu_dec
    import rv_pkg::*;
(
    input  logic [6:0] opcode,
    input  logic [2:0] funct3,
    input  logic       funct7_5,
    output logic [3:0] alu_cmd,
    output logic       alu_src,
    output logic       illegal
);

    // Pure decode of the latched instruction; branch funct3 010/011 has no meaning
    always_comb begin
        alu_cmd = ALU_ADD;
        alu_src = 1'b0;
        illegal = 1'b0;
        case (opcode)
            OP_R: begin
                alu_cmd = {funct7_5, funct3};
            end
            OP_I: begin
                // funct7_5 only distinguishes srli/srai; for other I-ops it is immediate bits
                alu_cmd = {funct7_5 & (funct3 == 3'b101), funct3};
                alu_src = 1'b1;
            end
            OP_LUI: begin
                alu_cmd = ALU_PASS_B;
                alu_src = 1'b1;
            end
            OP_LOAD, OP_STORE: begin
                alu_src = 1'b1;
            end
            OP_BRANCH: begin
                alu_cmd = ALU_SUB;
                illegal = (funct3[2:1] == 2'b01);
            end
            OP_JAL: begin
                alu_src = 1'b0;
            end
            OP_JALR: begin
                // jalr target is rs1 + immediate, so the ALU takes the immediate operand
                alu_src = 1'b1;
            end
            default: begin
                illegal = 1'b1;
            end
        endcase
    end

endmodule

// File: rtl/uc_mc.sv
// rtl/uc_mc.sv - multi-cycle RV-style control unit with memory watchdog and trap handling
module uc_mc
    import rv_pkg::*;
#(
    parameter int unsigned TIMEOUT      = 16,
    parameter bit          HALT_ON_TRAP = 1'b1
) (
    input  logic           clk,
    input  logic           rst_n,
    input  logic [6:0]     opcode,
    input  logic [2:0]     funct3,
    input  logic           funct7_5,
    input  logic [3:0]     alu_flags,
    uc_mc_if.master        mem,
    output logic           ir_we,
    output logic           mdr_we,
    output logic           pc_we,
    output logic           rf_we,
    output logic           alu_src,
    output logic [1:0]     pc_src,
    output logic [1:0]     rf_src,
    output logic [3:0]     alu_cmd,
    output logic           trap,
    output logic [1:0]     trap_cause
);

    localparam int CW = (TIMEOUT < 2) ? 1 : $clog2(TIMEOUT + 1);
    localparam logic [CW:0] WD_LIMIT = (CW + 1)'(TIMEOUT);

    logic [2:0]    state;
    logic [2:0]    state_nx;
    trap_cause_e   cause;
    trap_cause_e   cause_nx;
    logic [CW-1:0] wd_cnt;
    logic          wd_active;
    logic          wd_hit;

    logic [3:0]    dec_cmd;
    logic          dec_src;
    logic          dec_illegal;

    logic          c_i_req;
    logic          c_d_req;
    logic          c_d_we;
    logic          c_ir_we;
    logic          c_mdr_we;
    logic          c_pc_we;
    logic          c_rf_we;
    logic          c_alu_src;
    logic [1:0]    c_pc_src;
    logic [1:0]    c_rf_src;
    logic [3:0]    c_alu_cmd;
    logic          c_trap;

    rv_alu_dec u_alu_dec (
        .opcode   (opcode),
        .funct3   (funct3),
        .funct7_5 (funct7_5),
        .alu_cmd  (dec_cmd),
        .alu_src  (dec_src),
        .illegal  (dec_illegal)
    );

    // A wait cycle is any request cycle without its ack; acks outside requests never count
    assign wd_active = ((state == ST_FETCH) && !mem.i_ack) || ((state == ST_MEM) && !mem.d_ack);
    // Ack takes priority: this is only consulted on cycles that were not acked
    assign wd_hit    = (TIMEOUT != 0) && (({1'b0, wd_cnt} + 1'b1) == WD_LIMIT);

    // Next-state and per-state control outputs
    always_comb begin
        state_nx  = state;
        cause_nx  = cause;
        c_i_req   = 1'b0;
        c_d_req   = 1'b0;
        c_d_we    = 1'b0;
        c_ir_we   = 1'b0;
        c_mdr_we  = 1'b0;
        c_pc_we   = 1'b0;
        c_rf_we   = 1'b0;
        c_alu_src = 1'b0;
        c_pc_src  = PC_PLUS4;
        c_rf_src  = RF_ALU;
        c_alu_cmd = ALU_ADD;
        c_trap    = 1'b0;
        case (state)
            ST_FETCH: begin
                c_i_req = 1'b1;
                if (mem.i_ack) begin
                    c_ir_we  = 1'b1;
                    state_nx = ST_DECODE;
                end else if (wd_hit) begin
                    state_nx = ST_TRAP;
                    cause_nx = CAUSE_TIMEOUT;
                end
            end
            ST_DECODE: begin
                if (dec_illegal) begin
                    state_nx = ST_TRAP;
                    cause_nx = CAUSE_ILLEGAL;
                end else begin
                    state_nx = ST_EXEC;
                end
            end
            ST_EXEC: begin
                c_alu_cmd = dec_cmd;
                c_alu_src = dec_src;
                case (opcode)
                    OP_BRANCH: begin
                        c_pc_we  = 1'b1;
                        c_pc_src = branch_taken(funct3, alu_flags) ? PC_TARGET : PC_PLUS4;
                        state_nx = ST_FETCH;
                    end
                    OP_JAL, OP_JALR: begin
                        c_rf_we  = 1'b1;
                        c_rf_src = RF_PC4;
                        c_pc_we  = 1'b1;
                        c_pc_src = (opcode == OP_JAL) ? PC_TARGET : PC_JALR;
                        state_nx = ST_FETCH;
                    end
                    OP_LOAD, OP_STORE: begin
                        state_nx = ST_MEM;
                    end
                    default: begin
                        state_nx = ST_WB;
                    end
                endcase
            end
            ST_MEM: begin
                c_d_req = 1'b1;
                c_d_we  = (opcode == OP_STORE);
                if (mem.d_ack) begin
                    if (opcode == OP_STORE) begin
                        c_pc_we  = 1'b1;
                        state_nx = ST_FETCH;
                    end else begin
                        c_mdr_we = 1'b1;
                        state_nx = ST_WB;
                    end
                end else if (wd_hit) begin
                    state_nx = ST_TRAP;
                    cause_nx = CAUSE_TIMEOUT;
                end
            end
            ST_WB: begin
                c_rf_we  = 1'b1;
                c_rf_src = (opcode == OP_LOAD) ? RF_MDR : RF_ALU;
                c_pc_we  = 1'b1;
                state_nx = ST_FETCH;
            end
            ST_TRAP: begin
                c_trap = 1'b1;
                if (!HALT_ON_TRAP) begin
                    c_pc_we  = 1'b1;
                    c_pc_src = PC_TRAP;
                    state_nx = ST_FETCH;
                    cause_nx = CAUSE_NONE;
                end
            end
            default: begin
                state_nx = ST_FETCH;
            end
        endcase
    end

    // State, trap cause and watchdog registers; counter restarts whenever a wait ends
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state  <= ST_FETCH;
            cause  <= CAUSE_NONE;
            wd_cnt <= '0;
        end else begin
            state  <= state_nx;
            cause  <= cause_nx;
            wd_cnt <= wd_active ? wd_cnt + 1'b1 : '0;
        end
    end

    // Everything is forced quiet while reset is held, independent of state
    assign mem.i_req  = rst_n & c_i_req;
    assign mem.d_req  = rst_n & c_d_req;
    assign mem.d_we   = rst_n & c_d_we;
    assign ir_we      = rst_n & c_ir_we;
    assign mdr_we     = rst_n & c_mdr_we;
    assign pc_we      = rst_n & c_pc_we;
    assign rf_we      = rst_n & c_rf_we;
    assign alu_src    = rst_n & c_alu_src;
    assign pc_src     = rst_n ? c_pc_src  : 2'b00;
    assign rf_src     = rst_n ? c_rf_src  : 2'b00;
    assign alu_cmd    = rst_n ? c_alu_cmd : 4'b0000;
    assign trap       = rst_n & c_trap;
    assign trap_cause = rst_n ? cause     : 2'b00;

endmodule

// File: tb/tb_uc_mc.sv
// tb/tb_uc_mc.sv - self-checking bench for uc_mc with a behavioural instruction-timing model
module tb_uc_mc;

    localparam int T = 4;

    typedef struct {
        int cycles;
        int n_ireq;
        int n_dreq;
        int d_we;
        int n_ir;
        int n_mdr;
        int n_rf;
        int rf_cyc;
        int rf_src;
        int pc_src;
        int alu_cmd;
        int alu_src;
        int trap;
        int cause;
    } res_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [6:0] opcode = '0;
    logic [2:0] funct3 = '0;
    logic       funct7_5 = 1'b0;
    logic [3:0] alu_flags = '0;
    logic       i_ack = 1'b0;
    logic       d_ack = 1'b0;
    int         checks = 0;
    int         failures = 0;
    logic [6:0] ops [10];

    always #5 clk = ~clk;

    uc_mc_if r_if ();
    uc_mc_if h_if ();
    assign r_if.i_ack = i_ack;
    assign r_if.d_ack = d_ack;
    assign h_if.i_ack = i_ack;
    assign h_if.d_ack = d_ack;

    logic       r_ir_we, r_mdr_we, r_pc_we, r_rf_we, r_alu_src, r_trap;
    logic [1:0] r_pc_src, r_rf_src, r_trap_cause;
    logic [3:0] r_alu_cmd;
    logic       h_ir_we, h_mdr_we, h_pc_we, h_rf_we, h_alu_src, h_trap;
    logic [1:0] h_pc_src, h_rf_src, h_trap_cause;
    logic [3:0] h_alu_cmd;
    logic [18:0] r_all, h_all;

    assign r_all = {r_if.i_req, r_if.d_req, r_if.d_we, r_ir_we, r_mdr_we, r_pc_we, r_rf_we,
                    r_alu_src, r_pc_src, r_rf_src, r_alu_cmd, r_trap, r_trap_cause};
    assign h_all = {h_if.i_req, h_if.d_req, h_if.d_we, h_ir_we, h_mdr_we, h_pc_we, h_rf_we,
                    h_alu_src, h_pc_src, h_rf_src, h_alu_cmd, h_trap, h_trap_cause};

    uc_mc #(.TIMEOUT(T), .HALT_ON_TRAP(1'b0)) dut_r (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .alu_flags(alu_flags), .mem(r_if), .ir_we(r_ir_we), .mdr_we(r_mdr_we), .pc_we(r_pc_we),
        .rf_we(r_rf_we), .alu_src(r_alu_src), .pc_src(r_pc_src), .rf_src(r_rf_src),
        .alu_cmd(r_alu_cmd), .trap(r_trap), .trap_cause(r_trap_cause)
    );

    uc_mc #(.TIMEOUT(T), .HALT_ON_TRAP(1'b1)) dut_h (
        .clk(clk), .rst_n(rst_n), .opcode(opcode), .funct3(funct3), .funct7_5(funct7_5),
        .alu_flags(alu_flags), .mem(h_if), .ir_we(h_ir_we), .mdr_we(h_mdr_we), .pc_we(h_pc_we),
        .rf_we(h_rf_we), .alu_src(h_alu_src), .pc_src(h_pc_src), .rf_src(h_rf_src),
        .alu_cmd(h_alu_cmd), .trap(h_trap), .trap_cause(h_trap_cause)
    );

    task automatic check(input string tag, input int obs, input int exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
        end
    endtask

    // Flags of a - b on 8-bit operands, and whether the branch should be taken
    task automatic mk_flags(input logic [7:0] a, input logic [7:0] b, input logic [2:0] f3,
                            output logic [3:0] fl, output logic taken);
        logic [7:0] d;
        d = a - b;
        fl = {(d == 8'd0), d[7], (a >= b), (a[7] != b[7]) && (d[7] != a[7])};
        case (f3)
            3'd0:    taken = (a == b);
            3'd1:    taken = (a != b);
            3'd4:    taken = ($signed(a) < $signed(b));
            3'd5:    taken = ($signed(a) >= $signed(b));
            3'd6:    taken = (a < b);
            3'd7:    taken = (a >= b);
            default: taken = 1'b0;
        endcase
    endtask

    // Expected per-instruction outcome from the instruction class and memory wait lengths
    task automatic model(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic taken,
                         input int idly, input int ddly, output res_t e);
        bit legal;
        e = '{default: 0};
        legal = (op inside {7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                            7'b1101111, 7'b1100111, 7'b0110111})
                && !(op == 7'b1100011 && (f3 == 3'd2 || f3 == 3'd3));
        if (idly >= T) begin
            e.cycles = T + 1; e.n_ireq = T; e.pc_src = 3; e.trap = 1; e.cause = 2;
            return;
        end
        e.n_ireq = idly + 1;
        e.n_ir = 1;
        if (!legal) begin
            e.cycles = idly + 3; e.pc_src = 3; e.trap = 1; e.cause = 1;
            return;
        end
        case (op)
            7'b0110011: begin e.alu_cmd = 8 * int'(f7) + int'(f3); e.alu_src = 0; end
            7'b0010011: begin e.alu_cmd = ((f3 == 3'd5) ? 8 * int'(f7) : 0) + int'(f3); e.alu_src = 1; end
            7'b0110111: begin e.alu_cmd = 15; e.alu_src = 1; end
            7'b1100011: begin e.alu_cmd = 8; e.alu_src = 0; end
            7'b1100111: begin e.alu_cmd = 0; e.alu_src = 1; end
            7'b1101111: begin e.alu_cmd = 0; e.alu_src = 0; end
            default:    begin e.alu_cmd = 0; e.alu_src = 1; end
        endcase
        if (op == 7'b0000011 || op == 7'b0100011) begin
            e.d_we = (op == 7'b0100011) ? 1 : 0;
            if (ddly >= T) begin
                e.n_dreq = T; e.cycles = idly + T + 4; e.pc_src = 3; e.trap = 1; e.cause = 2;
                return;
            end
            e.n_dreq = ddly + 1;
            if (op == 7'b0000011) begin
                e.cycles = idly + ddly + 5; e.n_mdr = 1; e.n_rf = 1; e.rf_src = 1; e.rf_cyc = e.cycles;
            end else begin
                e.cycles = idly + ddly + 4;
            end
        end else if (op == 7'b1100011) begin
            e.cycles = idly + 3; e.pc_src = taken ? 1 : 0;
        end else if (op == 7'b1101111 || op == 7'b1100111) begin
            e.cycles = idly + 3; e.n_rf = 1; e.rf_src = 2; e.rf_cyc = e.cycles;
            e.pc_src = (op == 7'b1101111) ? 1 : 2;
        end else begin
            e.cycles = idly + 4; e.n_rf = 1; e.rf_src = 0; e.rf_cyc = e.cycles;
        end
    endtask

    // Runs one instruction on dut_r with acks after idly/ddly wait cycles; random acks when idle
    task automatic run(input logic [6:0] op, input logic [2:0] f3, input logic f7, input logic [3:0] fl,
                       input int idly, input int ddly, input int stop_at, output res_t o);
        int iw;
        int dw;
        o = '{default: 0};
        iw = 0;
        dw = 0;
        opcode = op; funct3 = f3; funct7_5 = f7; alu_flags = fl;
        for (int c = 1; c <= 40; c++) begin
            if (r_if.i_req) begin i_ack = (iw == idly); iw++; end
            else i_ack = 1'($urandom_range(0, 1));
            if (r_if.d_req) begin d_ack = (dw == ddly); dw++; end
            else d_ack = 1'($urandom_range(0, 1));
            #1;
            if (r_if.i_req) o.n_ireq++;
            if (r_ir_we) o.n_ir++;
            if (r_if.d_req) begin o.n_dreq++; if (r_if.d_we) o.d_we = 1; end
            if (r_mdr_we) o.n_mdr++;
            if (r_rf_we) begin o.n_rf++; o.rf_src = int'(r_rf_src); o.rf_cyc = c; end
            if (c == idly + 3) begin o.alu_cmd = int'(r_alu_cmd); o.alu_src = int'(r_alu_src); end
            if (c == stop_at) begin o.cycles = c; return; end
            if (r_pc_we) begin
                o.cycles = c; o.pc_src = int'(r_pc_src); o.trap = int'(r_trap); o.cause = int'(r_trap_cause);
                @(posedge clk); #1;
                return;
            end
            @(posedge clk); #1;
        end
        o.cycles = -1;
    endtask

    task automatic compare(input string tag, input res_t o, input res_t e);
        check({tag, ".cycles"}, o.cycles, e.cycles);
        check({tag, ".n_ireq"}, o.n_ireq, e.n_ireq);
        check({tag, ".n_dreq"}, o.n_dreq, e.n_dreq);
        check({tag, ".d_we"}, o.d_we, e.d_we);
        check({tag, ".n_ir"}, o.n_ir, e.n_ir);
        check({tag, ".n_mdr"}, o.n_mdr, e.n_mdr);
        check({tag, ".n_rf"}, o.n_rf, e.n_rf);
        check({tag, ".rf_cyc"}, o.rf_cyc, e.rf_cyc);
        check({tag, ".rf_src"}, o.rf_src, e.rf_src);
        check({tag, ".pc_src"}, o.pc_src, e.pc_src);
        check({tag, ".alu_cmd"}, o.alu_cmd, e.alu_cmd);
        check({tag, ".alu_src"}, o.alu_src, e.alu_src);
        check({tag, ".trap"}, o.trap, e.trap);
        check({tag, ".cause"}, o.cause, e.cause);
    endtask

    task automatic do_reset(input string tag);
        rst_n = 1'b0; i_ack = 1'b0; d_ack = 1'b0;
        @(posedge clk); #2;
        check({tag, ".r_outs"}, int'(r_all), 0);
        check({tag, ".h_outs"}, int'(h_all), 0);
        @(posedge clk); #1;
        rst_n = 1'b1;
        #1;
        check({tag, ".r_ireq"}, int'(r_if.i_req), 1);
        check({tag, ".h_ireq"}, int'(h_if.i_req), 1);
    endtask

    task automatic directed(input string tag, input logic [6:0] op, input logic [2:0] f3, input logic f7,
                            input logic [7:0] a, input logic [7:0] b, input int idly, input int ddly);
        res_t e, o;
        logic [3:0] fl;
        logic tk;
        mk_flags(a, b, f3, fl, tk);
        model(op, f3, f7, tk, idly, ddly, e);
        run(op, f3, f7, fl, idly, ddly, 0, o);
        compare(tag, o, e);
    endtask

    initial begin
        res_t e, o;
        logic [7:0] a, b;
        logic [3:0] fl;
        logic tk;
        logic [6:0] op;
        logic [2:0] f3;
        logic f7;
        int idly, ddly;

        ops = '{7'b0110011, 7'b0010011, 7'b0000011, 7'b0100011, 7'b1100011,
                7'b1101111, 7'b1100111, 7'b0110111, 7'b1111111, 7'b0000000};

        do_reset("rst0");
        directed("add",      7'b0110011, 3'd0, 1'b0, 8'd3, 8'd1, 0, 0);
        directed("sub_i3",   7'b0110011, 3'd0, 1'b1, 8'd3, 8'd1, 3, 0);
        directed("srai",     7'b0010011, 3'd5, 1'b1, 8'd0, 8'd0, 1, 0);
        directed("lui",      7'b0110111, 3'd2, 1'b1, 8'd0, 8'd0, 0, 0);
        directed("load_d3",  7'b0000011, 3'd2, 1'b0, 8'd0, 8'd0, 0, 3);
        directed("store_d0", 7'b0100011, 3'd2, 1'b0, 8'd0, 8'd0, 0, 0);
        directed("store_d3", 7'b0100011, 3'd2, 1'b0, 8'd0, 8'd0, 0, 3);
        directed("bne_tk",   7'b1100011, 3'd1, 1'b0, 8'd1, 8'd2, 0, 0);
        directed("bne_nt",   7'b1100011, 3'd1, 1'b0, 8'd5, 8'd5, 0, 0);
        directed("jal",      7'b1101111, 3'd0, 1'b0, 8'd0, 8'd0, 0, 0);
        directed("jalr",     7'b1100111, 3'd0, 1'b0, 8'd0, 8'd0, 0, 0);
        directed("illegal",  7'b1111111, 3'd0, 1'b0, 8'd0, 8'd0, 0, 0);

        check("halt.h_trap", int'(h_trap), 1);
        check("halt.h_cause", int'(h_trap_cause), 1);
        check("halt.r_ireq", int'(r_if.i_req), 1);
        check("halt.r_trap", int'(r_trap), 0);
        i_ack = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        check("halt.h_trap_held", int'(h_trap), 1);
        check("halt.h_cause_held", int'(h_trap_cause), 1);
        check("halt.h_pc_we", int'(h_pc_we), 0);
        check("halt.h_ireq", int'(h_if.i_req), 0);
        do_reset("rst1");

        directed("ifetch_to", 7'b0110011, 3'd0, 1'b0, 8'd0, 8'd0, 100, 0);
        directed("load_to",   7'b0000011, 3'd2, 1'b0, 8'd0, 8'd0, 0, 100);
        directed("beq_bad",   7'b1100011, 3'd2, 1'b0, 8'd0, 8'd0, 0, 0);

        for (int k = 0; k < 60; k++) begin
            op = ops[$urandom_range(0, 9)];
            f3 = 3'($urandom);
            f7 = 1'($urandom);
            a = 8'($urandom);
            b = ($urandom_range(0, 3) == 0) ? a : 8'($urandom);
            idly = $urandom_range(0, 4);
            ddly = $urandom_range(0, 4);
            mk_flags(a, b, f3, fl, tk);
            model(op, f3, f7, tk, idly, ddly, e);
            run(op, f3, f7, fl, idly, ddly, 0, o);
            compare($sformatf("rnd%0d", k), o, e);
        end

        run(7'b0000011, 3'd2, 1'b0, 4'd0, 0, 10, 5, o);
        check("memrst.cycles", o.cycles, 5);
        check("memrst.n_dreq", o.n_dreq, 2);
        check("memrst.dreq_now", int'(r_if.d_req), 1);
        do_reset("rst2");
        directed("add_post", 7'b0110011, 3'd7, 1'b0, 8'd0, 8'd0, 0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
